// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared game-state type and score/level widths for score_keeper
package score_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int SCORE_W = 8;
  localparam int LEVEL_W = 3;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - free-running toggle flag, flips every BLINK_CYCLES enabled cycles
module blink_timer #(
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic flag
);

  localparam int CW = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] count;

  // Dropping enable restarts the phase, so every entry begins with flag low.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (count == CNT_LAST) begin
      count <= '0;
      flag  <= ~flag;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - game FSM, saturating score, difficulty level and session high score
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned LEVEL_STEP   = 10,
  parameter int unsigned MAX_LEVEL    = 7,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               obstacle_passed,
  input  logic               collision,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [SCORE_W-1:0] display_score,
  output logic [LEVEL_W-1:0] level,
  output logic               playing,
  output logic               game_over,
  output logic               new_record
);

  localparam logic [SCORE_W-1:0] STEP_LAST = SCORE_W'(LEVEL_STEP - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_LEVEL);

  state_t             state, state_next;
  logic [SCORE_W-1:0] step_cnt;
  logic               enter_play;
  logic               show_high;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start)     state_next = PLAYING;
      PLAYING:   if (collision) state_next = GAME_OVER;
      GAME_OVER: if (start)     state_next = PLAYING;
      default:                  state_next = IDLE;
    endcase
  end

  assign enter_play = (state_next == PLAYING) && (state != PLAYING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      score      <= '0;
      high_score <= '0;
      level      <= '0;
      step_cnt   <= '0;
      new_record <= 1'b0;
    end else begin
      state <= state_next;
      if (enter_play) begin
        score      <= '0;
        level      <= '0;
        step_cnt   <= '0;
        new_record <= 1'b0;
      end else if (state == PLAYING) begin
        // A collision swallows any point arriving on the same edge.
        if (collision) begin
          if (score > high_score) begin
            high_score <= score;
            new_record <= 1'b1;
          end
        end else if (obstacle_passed && score != SCORE_MAX) begin
          score <= score + 1'b1;
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            if (level != LEVEL_TOP) level <= level + 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
      end
    end
  end

  blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .enable(state == GAME_OVER),
    .flag  (show_high)
  );

  assign playing   = (state == PLAYING);
  assign game_over = (state == GAME_OVER);

  always_comb begin
    display_score = score;
    case (state)
      IDLE:      display_score = high_score;
      GAME_OVER: display_score = show_high ? high_score : score;
      default:   display_score = score;
    endcase
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench for score_keeper against a rule-level game model
module tb_score_keeper;

  localparam int LS = 3;
  localparam int ML = 2;
  localparam int BC = 4;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       obstacle_passed = 1'b0;
  logic       collision = 1'b0;
  logic [7:0] score, high_score, display_score;
  logic [2:0] level;
  logic       playing, game_over, new_record;

  score_keeper #(
    .LEVEL_STEP  (LS),
    .MAX_LEVEL   (ML),
    .BLINK_CYCLES(BC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .obstacle_passed(obstacle_passed),
    .collision      (collision),
    .score          (score),
    .high_score     (high_score),
    .display_score  (display_score),
    .level          (level),
    .playing        (playing),
    .game_over      (game_over),
    .new_record     (new_record)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int hs;
    int disp;
    int level;
    int play;
    int over;
    int nr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  int m_state = M_IDLE;
  int m_score = 0;
  int m_hs = 0;
  int m_nr = 0;
  int m_go = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Level is simply completed steps of the current score, capped.
  function automatic exp_t model_outputs();
    exp_t e;
    int lv;
    lv = m_score / LS;
    if (lv > ML) lv = ML;
    e.score = m_score;
    e.hs    = m_hs;
    e.level = lv;
    e.play  = (m_state == M_PLAY);
    e.over  = (m_state == M_OVER);
    e.nr    = m_nr;
    if (m_state == M_IDLE)       e.disp = m_hs;
    else if (m_state == M_PLAY)  e.disp = m_score;
    else                         e.disp = (((m_go / BC) % 2) == 1) ? m_hs : m_score;
    return e;
  endfunction

  task automatic cycle(input bit r, input bit s, input bit o, input bit c);
    @(negedge clk);
    reset = r; start = s; obstacle_passed = o; collision = c;
    if (r) begin
      m_state = M_IDLE; m_score = 0; m_hs = 0; m_nr = 0; m_go = 0;
    end else begin
      case (m_state)
        M_IDLE: if (s) begin
          m_state = M_PLAY; m_score = 0; m_nr = 0;
        end
        M_PLAY: if (c) begin
          m_state = M_OVER; m_go = 0;
          if (m_score > m_hs) begin m_hs = m_score; m_nr = 1; end
        end else if (o && m_score < 255) begin
          m_score++;
        end
        default: if (s) begin
          m_state = M_PLAY; m_score = 0; m_nr = 0;
        end else begin
          m_go++;
        end
      endcase
    end
    exp_q.push_back(model_outputs());
  endtask

  task automatic play_game(input int pts);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < pts; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("score", int'(score), e.score);
        chk("high_score", int'(high_score), e.hs);
        chk("display_score", int'(display_score), e.disp);
        chk("level", int'(level), e.level);
        chk("playing", int'(playing), e.play);
        chk("game_over", int'(game_over), e.over);
        chk("new_record", int'(new_record), e.nr);
      end
    end
  end

  initial begin : driver
    int r;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    cycle(0, 0, 0, 0);

    // first game: five points, then idle pulses and a stray start while playing
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1);

    // saturation game
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 260; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0);

    // record, tie, then new record
    cycle(1, 0, 0, 0);
    play_game(7);
    play_game(7);
    play_game(8);

    // simultaneous collision and point, then watch the blink
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);

    // reset mid-game after a high score of 20, then pulses in idle
    cycle(1, 0, 0, 0);
    play_game(20);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      cycle(r < 3, ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
